cfs_md_rx_master: RTL
=====================

# cfs_md_rx_master

MD RX initiator: pops packed MD descriptors from an upstream source, drives them onto the Aligner's MD RX interface (`md_rx_valid`/`data`/`offset`/`size`), holds each packet until `md_rx_ready`, and records the responder's `md_rx_err` outcome in saturating counters. It sits at the opposite end of the MD RX link from the RX controller. It runs entirely in `md_rx_clk`, for embedding in sub-system test harnesses and upstream MD producers.

## Interface
- `ALGN_DATA_WIDTH`, 32, MD data width in bits; multiple of 8, ≥8.
- `CNT_WIDTH`, 8, width of `cnt_ok` and `cnt_err`.
- `GAP_WIDTH`, 4, width of `gap_cycles`.
- Derived:
  - `OFFSET_W` = `ALGN_DATA_WIDTH<=8 ? 1 : $clog2(ALGN_DATA_WIDTH/8)`.
  - `SIZE_W` = `$clog2(ALGN_DATA_WIDTH/8)+1`.
  - `FIFO_W` = `ALGN_DATA_WIDTH+OFFSET_W+SIZE_W`.

Ports:
- `md_rx_clk`  in  1  clock.
- `preset_n`  in  1  reset: asynchronous, active-low.
- `clr_cnt`  in  1  synchronous clear of both counters, level-sampled.
- `gap_cycles`  in  GAP_WIDTH  minimum idle cycles inserted after each completed packet; sampled at completion.
- `pop_valid`  in  1  descriptor available.
- `pop_data`  in  FIFO_W  packed descriptor `{size, offset, data}`: data in LSBs, size in MSBs.
- `pop_ready`  out  1  descriptor accepted this cycle.
- `md_rx_valid`  out  1  MD packet valid.
- `md_rx_data`  out  ALGN_DATA_WIDTH  MD data.
- `md_rx_offset`  out  OFFSET_W  MD offset.
- `md_rx_size`  out  SIZE_W  MD size.
- `md_rx_ready`  in  1  responder accepts or rejects.
- `md_rx_err`  in  1  responder rejected the packet; meaningful only when `md_rx_valid & md_rx_ready`.
- `cnt_ok`  out  CNT_WIDTH  packets accepted without error; saturating.
- `cnt_err`  out  CNT_WIDTH  packets rejected; saturating.
- `err_pulse`  out  1  one-cycle pulse per rejected packet.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **FSM states:** IDLE, DRIVE, GAP. Reset → IDLE.
- **IDLE:**
  - `pop_ready`=1.
  - On `pop_valid`: register the unpacked fields into the `md_rx_*` output registers, set `md_rx_valid`=1, go to DRIVE.
- **DRIVE:**
  - Outputs are held stable until a completion edge (`md_rx_valid & md_rx_ready` sampled high).
  - At completion, if `md_rx_err`: `cnt_err`++ (saturating at 2^CNT_WIDTH−1) and `err_pulse`=1 next cycle. Otherwise `cnt_ok`++ (saturating).
  - At completion with `gap_cycles`=0: `pop_ready` = `md_rx_ready` (combinational). If `pop_valid`, load the next descriptor and stay in DRIVE (back-to-back). Otherwise `md_rx_valid`←0 and go to IDLE.
  - At completion with `gap_cycles`=N>0: `md_rx_valid`←0, load the gap counter with N, go to GAP.
  - `pop_ready`=0 in DRIVE except as above.
- **GAP:**
  - `pop_ready`=0; decrement each cycle.
  - When the counter reaches 1 (i.e. after N GAP cycles), go to IDLE.
- **Counters:**
  - `clr_cnt`=1 clears both counters to 0 at the edge.
  - Clear wins over a simultaneous increment.
- **Reset:**
  - Asynchronous assertion at any time, including mid-DRIVE, forces IDLE. An in-flight packet is dropped and is not counted.
  - All outputs reset to 0: `md_rx_valid`, data/offset/size, `cnt_ok`, `cnt_err`, `err_pulse`, `busy`. `pop_ready` also reads 0 while reset is asserted.
- The block performs no legality check. Illegal size/offset combinations are driven as given; the responder flags them via `md_rx_err`.

## Timing
- Pop accepted at edge k → `md_rx_valid`=1 from edge k through the completion edge.
- Completion at edge c:
  - Counters and `err_pulse` are visible after c.
  - Back-to-back (gap=0, `pop_valid`=1): new packet visible after c, and `md_rx_valid` never drops.
  - gap=0, no descriptor: `md_rx_valid` is low ≥1 cycle.
  - gap=N>0: `md_rx_valid` is low for exactly N+1 cycles when a descriptor is waiting (N GAP cycles + 1 IDLE cycle).
- `md_rx_ready` high at the first DRIVE edge → 1-cycle transfer.
- `md_rx_ready` low indefinitely → the block stalls in DRIVE; no timeout.
- `err_pulse` is exactly 1 cycle wide per rejection.

## Structure
- Package `cfs_md_pkg`:
  - width functions for `OFFSET_W`/`SIZE_W`/`FIFO_W`;
  - field MSB/LSB constants;
  - FSM enum `md_master_state_t` {IDLE, DRIVE, GAP}.
- Sub-module `cfs_sat_cnt`: saturating counter with `inc`/`clr` and clear priority. Instantiated twice, for `cnt_ok` and `cnt_err`.

## Test plan
- **Legal packet:** DATA_WIDTH=32; pop `{size=4, offset=0, data=0xDEADBEEF}`, `md_rx_ready` high after 3 cycles → `md_rx_valid` held with stable fields for 3 cycles; `cnt_ok`=1, `cnt_err`=0, `err_pulse` never high.
- **Rejected packet:** `size=0`, responder returns `md_rx_err`=1 with ready → `cnt_err`=1, `err_pulse` exactly 1 cycle, `cnt_ok` unchanged.
- **Back-to-back vs gap:** 3 descriptors queued, ready tied high, gap=0 → `md_rx_valid` high 3 consecutive cycles. Same with gap=2 → each low period exactly 3 cycles.
- **Saturation and clear:** CNT_WIDTH=2; 5 rejected packets → `cnt_err`=3. `clr_cnt` on the same edge as a 6th rejection → `cnt_err`=0.
- **Reset mid-packet:** assert `preset_n`=0 in DRIVE with ready low → `md_rx_valid`=0 immediately and counters 0. After release, the next pop drives a fresh packet.

Source files
------------

// File: rtl/cfs_md_pkg.sv
// Shared widths, packed-descriptor field positions and FSM encoding for the
// MD RX initiator.
package cfs_md_pkg;

  function automatic int offset_w(input int dw);
    return (dw <= 8) ? 1 : $clog2(dw / 8);
  endfunction

  function automatic int size_w(input int dw);
    return $clog2(dw / 8) + 1;
  endfunction

  function automatic int fifo_w(input int dw);
    return dw + offset_w(dw) + size_w(dw);
  endfunction

  // Descriptor layout {size, offset, data}, data in the LSBs.
  function automatic int data_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int offset_lsb(input int dw);
    return dw;
  endfunction

  function automatic int offset_msb(input int dw);
    return dw + offset_w(dw) - 1;
  endfunction

  function automatic int size_lsb(input int dw);
    return dw + offset_w(dw);
  endfunction

  function automatic int size_msb(input int dw);
    return dw + offset_w(dw) + size_w(dw) - 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } md_master_state_t;

endpackage

// File: rtl/cfs_sat_cnt.sv
// Saturating up-counter; a synchronous clear overrides a simultaneous increment.
module cfs_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             md_rx_clk,
  input  logic             preset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge md_rx_clk or negedge preset_n) begin
    if (!preset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cfs_md_rx_master.sv
// MD RX initiator: pops packed descriptors, holds each on the MD RX link until
// the responder handshakes, and counts accepted / rejected packets.
module cfs_md_rx_master
  import cfs_md_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = 8,
  parameter int GAP_WIDTH       = 4,
  localparam int OFFSET_W       = offset_w(ALGN_DATA_WIDTH),
  localparam int SIZE_W         = size_w(ALGN_DATA_WIDTH),
  localparam int FIFO_W         = fifo_w(ALGN_DATA_WIDTH)
) (
  input  logic                       md_rx_clk,
  input  logic                       preset_n,
  input  logic                       clr_cnt,
  input  logic [GAP_WIDTH-1:0]       gap_cycles,
  input  logic                       pop_valid,
  input  logic [FIFO_W-1:0]          pop_data,
  output logic                       pop_ready,
  output logic                       md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  output logic [OFFSET_W-1:0]        md_rx_offset,
  output logic [SIZE_W-1:0]          md_rx_size,
  input  logic                       md_rx_ready,
  input  logic                       md_rx_err,
  output logic [CNT_WIDTH-1:0]       cnt_ok,
  output logic [CNT_WIDTH-1:0]       cnt_err,
  output logic                       err_pulse,
  output logic                       busy
);

  localparam int DATA_MSB = data_msb(ALGN_DATA_WIDTH);
  localparam int OFF_LSB  = offset_lsb(ALGN_DATA_WIDTH);
  localparam int OFF_MSB  = offset_msb(ALGN_DATA_WIDTH);
  localparam int SIZE_LSB = size_lsb(ALGN_DATA_WIDTH);
  localparam int SIZE_MSB = size_msb(ALGN_DATA_WIDTH);

  md_master_state_t             state_q, state_d;
  logic [GAP_WIDTH-1:0]         gap_q, gap_d;
  logic                         valid_q, valid_d;
  logic [ALGN_DATA_WIDTH-1:0]   data_q, data_d;
  logic [OFFSET_W-1:0]          offset_q, offset_d;
  logic [SIZE_W-1:0]            size_q, size_d;
  logic                         err_pulse_q, err_pulse_d;
  logic                         accept;
  logic                         done;

  assign done = (state_q == DRIVE) && valid_q && md_rx_ready;

  // NOTE: every _d signal gets its default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    valid_d     = valid_q;
    data_d      = data_q;
    offset_d    = offset_q;
    size_d      = size_q;
    err_pulse_d = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: accept = 1'b1;
      DRIVE: begin
        if (done) begin
          err_pulse_d = md_rx_err;
          if (gap_cycles == '0) begin
            // Back-to-back: a waiting descriptor replaces this one without a bubble.
            accept = 1'b1;
            if (!pop_valid) begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            valid_d = 1'b0;
            gap_d   = gap_cycles;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAP_WIDTH'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && pop_valid) begin
      data_d   = pop_data[DATA_MSB:0];
      offset_d = pop_data[OFF_MSB:OFF_LSB];
      size_d   = pop_data[SIZE_MSB:SIZE_LSB];
      valid_d  = 1'b1;
      state_d  = DRIVE;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge md_rx_clk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      offset_q    <= '0;
      size_q      <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      offset_q    <= offset_d;
      size_q      <= size_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  cfs_sat_cnt #(.WIDTH(CNT_WIDTH)) u_cnt_ok (
    .md_rx_clk (md_rx_clk),
    .preset_n  (preset_n),
    .clr       (clr_cnt),
    .inc       (done && !md_rx_err),
    .count     (cnt_ok)
  );

  cfs_sat_cnt #(.WIDTH(CNT_WIDTH)) u_cnt_err (
    .md_rx_clk (md_rx_clk),
    .preset_n  (preset_n),
    .clr       (clr_cnt),
    .inc       (done && md_rx_err),
    .count     (cnt_err)
  );

  assign pop_ready    = accept && preset_n;
  assign md_rx_valid  = valid_q;
  assign md_rx_data   = data_q;
  assign md_rx_offset = offset_q;
  assign md_rx_size   = size_q;
  assign err_pulse    = err_pulse_q;
  assign busy         = (state_q != IDLE);

endmodule
